// File: rtl/token_crc_5_tx_pkg.sv
// Shared USB token definitions: CRC5 constants, token geometry and the transmitter state type.
// Also holds the single-bit CRC5 step and the wire-order field mapping used by generator and transmitter.
package usb_pkg;

    localparam int TOKEN_BODY_W = 11;
    localparam int CRC5_W       = 5;

    localparam logic [CRC5_W-1:0] CRC5_POLY     = 5'h05;
    localparam logic [CRC5_W-1:0] CRC5_INIT     = 5'b11111;
    localparam logic [CRC5_W-1:0] CRC5_RESIDUAL = 5'b01100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CRC
    } tx_state_t;

    function automatic logic [CRC5_W-1:0] crc5_next(input logic [CRC5_W-1:0] crc,
                                                    input logic              b);
        logic fb;
        fb = crc[CRC5_W-1] ^ b;
        return {crc[CRC5_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : {CRC5_W{1'b0}});
    endfunction

    // Field sent on the wire is the complemented register, MSB first, so bit-reversed in LSB-first order.
    function automatic logic [CRC5_W-1:0] crc5_field(input logic [CRC5_W-1:0] crc);
        logic [CRC5_W-1:0] f;
        for (int i = 0; i < CRC5_W; i++) begin
            f[i] = ~crc[CRC5_W-1-i];
        end
        return f;
    endfunction

endpackage

// File: rtl/token_crc_5_tx_if.sv
// Token transmitter bus: start/data request from the packet layer, serial bit stream and status back.
interface token_crc_5_tx_if;
    import usb_pkg::*;

    logic                    start;
    logic [TOKEN_BODY_W-1:0] token_data;
    logic                    shift_enable;
    logic                    serial_out;
    logic                    busy;
    logic                    done;
    logic [CRC5_W-1:0]       crc_out;

    modport master (
        output start, token_data, shift_enable,
        input  serial_out, busy, done, crc_out
    );

    modport slave (
        input  start, token_data, shift_enable,
        output serial_out, busy, done, crc_out
    );

endinterface

// File: rtl/token_crc_5_tx_crc_5_generator.sv
// Serial CRC5 register (x^5+x^2+1, MSB feedback) and the receive-side checker built on the same step.
// The checker's register settles to the fixed residual when a correct token body plus field is fed through.
module crc_5_generator
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              shift_enable,
    input  logic              serial_in,
    output logic [CRC5_W-1:0] crc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC5_INIT;
        end else if (clear) begin
            crc <= CRC5_INIT;
        end else if (shift_enable) begin
            crc <= crc5_next(crc, serial_in);
        end
    end

endmodule

module crc_5_checker
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              shift_enable,
    input  logic              serial_in,
    output logic [CRC5_W-1:0] crc
);

    crc_5_generator u_gen (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .crc          (crc)
    );

endmodule

// File: rtl/token_crc_5_tx.sv
// USB token body transmitter: shifts {endp, addr} LSB-first while accumulating CRC5,
// then appends the complemented, bit-reversed CRC field, one bit per shift_enable strobe.
module token_crc_5_tx
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    token_crc_5_tx_if.slave   bus
);

    localparam int CNT_W = 4;

    tx_state_t               state, state_nxt;
    logic [TOKEN_BODY_W-1:0] sr, sr_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    busy_q, busy_nxt;
    logic                    done_q, done_nxt;
    logic [CRC5_W-1:0]       crc_out_q, crc_out_nxt;
    logic                    crc_clear;
    logic                    data_shift;
    logic [CRC5_W-1:0]       crc;
    logic [CRC5_W-1:0]       field_next;

    crc_5_generator u_crc (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (crc_clear),
        .shift_enable (data_shift),
        .serial_in    (sr[0]),
        .crc          (crc)
    );

    // The field must be ready on the same edge that consumes the last body bit.
    assign field_next = crc5_field(crc5_next(crc, sr[0]));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_out_q <= '0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            crc_out_q <= crc_out_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        crc_out_nxt = crc_out_q;
        crc_clear   = 1'b0;
        data_shift  = 1'b0;

        case (state)
            ST_IDLE: begin
                // done_q blocks a restart on the edge that still shows the previous token's done.
                if (bus.start && !done_q) begin
                    sr_nxt    = bus.token_data;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    crc_clear = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.shift_enable) begin
                    data_shift = 1'b1;
                    if (cnt == CNT_W'(TOKEN_BODY_W - 1)) begin
                        sr_nxt      = {{(TOKEN_BODY_W-CRC5_W){1'b0}}, field_next};
                        crc_out_nxt = field_next;
                        cnt_nxt     = '0;
                        state_nxt   = ST_CRC;
                    end else begin
                        sr_nxt  = {1'b0, sr[TOKEN_BODY_W-1:1]};
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (bus.shift_enable) begin
                    sr_nxt = {1'b0, sr[TOKEN_BODY_W-1:1]};
                    if (cnt == CNT_W'(CRC5_W - 1)) begin
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.serial_out = sr[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.crc_out    = crc_out_q;

endmodule

// File: tb/tb_token_crc_5_tx.sv
// Directed bench for token_crc_5_tx: hand-computed token words, strobe pacing, restart blocking,
// asynchronous reset mid-token and loopback through crc_5_checker.
module tb_token_crc_5_tx;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    logic [15:0] got_word;
    int          got_bits;
    int          got_clocks;
    int          got_dones;
    logic        busy_ok;
    logic        first_bit;

    logic       chk_clear;
    logic       chk_se;
    logic [4:0] chk_crc;

    token_crc_5_tx_if bus();

    token_crc_5_tx dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    assign chk_clear = bus.start & ~bus.busy & ~bus.done;
    assign chk_se    = bus.busy & bus.shift_enable;

    crc_5_checker u_chk (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (chk_clear),
        .shift_enable (chk_se),
        .serial_in    (bus.serial_out),
        .crc          (chk_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one token; start edge always has shift_enable=1. Counting the start edge as clock 1.
    task automatic run_token(input logic [10:0] td, input int period, input bit poke);
        bit seen;
        got_word   = '0;
        got_bits   = 0;
        got_clocks = 0;
        got_dones  = 0;
        busy_ok    = 1'b1;
        seen       = 1'b0;
        bus.token_data   = td;
        bus.start        = 1'b1;
        bus.shift_enable = 1'b1;
        tick();
        bus.start  = 1'b0;
        got_clocks = 1;
        first_bit  = bus.serial_out;
        busy_ok    = busy_ok & bus.busy;
        for (int k = 1; k < 400 && !seen; k++) begin
            bus.shift_enable = ((k % period) == 0);
            if (poke && got_bits == 5 && bus.shift_enable) begin
                bus.start      = 1'b1;
                bus.token_data = 11'h7FF;
            end
            if (bus.busy && bus.shift_enable && got_bits < 16) begin
                got_word[got_bits] = bus.serial_out;
                got_bits++;
            end
            tick();
            bus.start = 1'b0;
            got_clocks++;
            if (bus.done) begin
                seen = 1'b1;
                got_dones++;
                busy_ok = busy_ok & ~bus.busy;
            end else begin
                busy_ok = busy_ok & bus.busy;
            end
        end
        bus.shift_enable = 1'b1;
        if (poke) begin
            bus.start      = 1'b1;
            bus.token_data = 11'h7FF;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done) got_dones++;
            if (bus.busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        bus.start        = 1'b0;
        bus.token_data   = '0;
        bus.shift_enable = 1'b0;

        #12;
        check("rst_serial_out", bus.serial_out, 1'b0);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_done",       bus.done,       1'b0);
        check("rst_crc_out",    bus.crc_out,    5'h00);
        check("rst_chk_crc",    chk_crc,        5'b11111);
        tick();
        n_rst = 1'b1;
        tick();
        tick();

        // addr=0, endp=0, strobe every clock: field 00010, word 0x1000
        run_token(11'h000, 1, 1'b0);
        check("t0_first_bit", first_bit,  1'b0);
        check("t0_word",      got_word,   16'h1000);
        check("t0_bits",      got_bits,   16);
        check("t0_crc_out",   bus.crc_out, 5'h02);
        check("t0_done_clk",  got_clocks, 17);
        check("t0_dones",     got_dones,  1);
        check("t0_busy",      busy_ok,    1'b1);
        check("t0_residual",  chk_crc,    5'b01100);
        check("t0_idle_so",   bus.serial_out, 1'b0);

        // addr=1, endp=0: field 11101, word 0xE801
        run_token(11'h001, 1, 1'b0);
        check("t1_first_bit", first_bit,     1'b1);
        check("t1_word",      got_word,      16'hE801);
        check("t1_hi_byte",   got_word[15:8], 8'hE8);
        check("t1_crc_out",   bus.crc_out,   5'h1D);
        check("t1_dones",     got_dones,     1);
        check("t1_residual",  chk_crc,       5'b01100);

        // Same as token 0 but strobe 1-of-4 clocks
        run_token(11'h000, 4, 1'b0);
        check("t4_word",      got_word,   16'h1000);
        check("t4_bits",      got_bits,   16);
        check("t4_dones",     got_dones,  1);
        check("t4_busy",      busy_ok,    1'b1);
        check("t4_crc_out",   bus.crc_out, 5'h02);
        check("t4_residual",  chk_crc,    5'b01100);

        // Restart pulses at body bit 5 and on the done edge carry 0x7FF; they must not take effect
        run_token(11'h001, 1, 1'b1);
        check("rs_word",      got_word,   16'hE801);
        check("rs_dones",     got_dones,  1);
        check("rs_busy",      busy_ok,    1'b1);
        check("rs_crc_out",   bus.crc_out, 5'h1D);

        // Reset during the CRC field, after two field bits have left
        bus.token_data   = 11'h001;
        bus.start        = 1'b1;
        bus.shift_enable = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        check("mr_pre_so",    bus.serial_out, 1'b1);
        check("mr_pre_busy",  bus.busy,       1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check("mr_so",        bus.serial_out, 1'b0);
        check("mr_busy",      bus.busy,       1'b0);
        check("mr_done",      bus.done,       1'b0);
        check("mr_crc_out",   bus.crc_out,    5'h00);
        tick();
        n_rst = 1'b1;
        got_dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.done) got_dones++;
        end
        check("mr_no_done",   got_dones, 0);
        check("mr_idle_busy", bus.busy,  1'b0);
        run_token(11'h001, 1, 1'b0);
        check("mr_word",      got_word,   16'hE801);
        check("mr_crc_out",   bus.crc_out, 5'h1D);
        check("mr_dones",     got_dones,  1);

        // Loopback: every correctly framed token leaves the checker at the fixed residual
        for (int n = 0; n < 6; n++) begin
            logic [10:0] td;
            int          per;
            td  = 11'($urandom);
            per = int'($urandom_range(1, 3));
            run_token(td, per, 1'b0);
            check("lb_body",     {5'h00, got_word[10:0]}, {5'h00, td});
            check("lb_field",    got_word[15:11], bus.crc_out);
            check("lb_residual", chk_crc,  5'b01100);
            check("lb_dones",    got_dones, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/token_crc_5_tx.md
TOKEN_CRC_5_TX -- requirements
Module: token_crc_5_tx

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 n_rst  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request to send one token body; sampled only in IDLE.
REQ-004 token_data  input  11  {endp[3:0], addr[6:0]}; captured on the accepted start edge.
REQ-005 shift_enable  input  1  bit strobe from the line-timing logic; one serial bit advances per enabled clock.
REQ-006 serial_out  output  1  current wire bit, LSB-first, registered source.
REQ-007 busy  output  1  high from the accepted start to the final CRC bit shift, inclusive.
REQ-008 done  output  1  one-clock pulse after the last CRC bit is shifted.
REQ-009 crc_out  output  5  CRC5 field as placed in token bits 15:11.

Function
REQ-010 Transmitted 16-bit word SHALL be {crc_field[4:0], endp[3:0], addr[6:0]}, sent bit 0 first.
REQ-011 CRC SHALL use polynomial x^5+x^2+1 (0x05), register initialised to 5'b11111 at start.
REQ-012 Per data bit b: fb = crc[4]^b; crc <= {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000).
REQ-013 crc_field[i] SHALL equal ~crc[4-i], i = 0..4 (complemented, bit-reversed).
REQ-014 FSM states: IDLE, DATA, CRC.
REQ-015 IDLE: start=1 at a rising edge -> load shift register with token_data, crc=11111, bit count=0, busy=1, enter DATA.
REQ-016 serial_out SHALL equal shift-register bit 0 at all times; token_data[0] is visible the cycle after start.
REQ-017 DATA: on each edge with shift_enable=1, update CRC with bit 0, shift right, increment count; no change when shift_enable=0.
REQ-018 On the 11th enabled DATA shift: load crc_field into shift register bits 4:0, register crc_out, enter CRC.
REQ-019 CRC: on each enabled edge, shift right; after the 5th enabled shift, enter IDLE, busy=0, done=1 for one clock.
REQ-020 start while busy=1 SHALL be ignored, including the edge on which done is asserted.
REQ-021 start asserted in IDLE together with shift_enable=1 SHALL accept start only; no bit is consumed on that edge.
REQ-022 crc_out SHALL hold its value from the DATA->CRC transition until the next DATA->CRC transition.
REQ-023 Latency: with shift_enable held high, done asserts 17 clocks after the accepted start edge.
REQ-024 serial_out in IDLE SHALL be 0.

Reset
REQ-025 n_rst=0 SHALL immediately force IDLE, serial_out=0, busy=0, done=0, crc_out=0, crc register=11111, count=0.
REQ-026 Reset mid-transmission SHALL abandon the token; no done pulse; the next start after release begins a fresh token.

Structure
REQ-027 Shared package usb_pkg SHALL hold CRC5_POLY, CRC5_INIT, TOKEN_BODY_W=11, CRC5_W=5 and the FSM state enum.
REQ-028 The CRC next-state step SHALL be a sub-module crc_5_generator (clk, n_rst, clear, shift_enable, serial_in, crc), compatible in polynomial and bit order with crc_5_checker.
REQ-029 Synthesisable RTL, single clock domain, no latches.

Verification
REQ-030 addr=0x00, endp=0x0, shift_enable held 1 -> crc_out=5'h02, wire sequence 11 zeros then 0,1,0,0,0; done at clock 17.
REQ-031 addr=0x01, endp=0x0 -> crc_out=5'h1D; bits 15:8 of the word = 8'hE8.
REQ-032 shift_enable toggled 1-of-4 clocks -> identical bit sequence to REQ-030; busy held through; done exactly once.
REQ-033 start pulsed again at DATA bit 5 and on the done edge -> ignored; a single token is output.
REQ-034 n_rst asserted during CRC bit 2 -> outputs zero asynchronously; a new start for addr=0x01 yields crc_out=5'h1D.
REQ-035 Loopback: serial_out into crc_5_checker over all 16 bits for random tokens -> checker residual 5'b01100 every time.
